// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry frame sequencer.
// The channel indices fix the payload word order that host software decodes.
package telemetry_pkg;

  localparam int unsigned N_WORDS   = 29;
  localparam logic [15:0] SYNC_WORD = 16'hA5C3;
  localparam int unsigned DECIM_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } state_t;

  localparam int unsigned ADC_SHEAR1  = 0;
  localparam int unsigned ADC_SHEAR2  = 1;
  localparam int unsigned ADC_SHEAR3  = 2;
  localparam int unsigned ADC_SHEAR4  = 3;
  localparam int unsigned ADC_OPD1    = 4;
  localparam int unsigned ADC_OPD2    = 5;
  localparam int unsigned ADC_OPD3    = 6;
  localparam int unsigned ADC_OPD4    = 7;
  localparam int unsigned ADC_AUX1    = 8;
  localparam int unsigned ADC_AUX2    = 9;
  localparam int unsigned ADC_AUX3    = 10;
  localparam int unsigned ADC_AUX4    = 11;
  localparam int unsigned OPD_COARSE  = 12;
  localparam int unsigned OPD_FINE    = 13;
  localparam int unsigned OPD_PHASE   = 14;
  localparam int unsigned OPD_RMS     = 15;
  localparam int unsigned SHEAR_X     = 16;
  localparam int unsigned SHEAR_Y     = 17;
  localparam int unsigned SHEAR_RMS   = 18;
  localparam int unsigned PNT_TIP     = 19;
  localparam int unsigned PNT_TILT    = 20;
  localparam int unsigned PNT_PISTON  = 21;
  localparam int unsigned PNT_AZ      = 22;
  localparam int unsigned PNT_EL      = 23;
  localparam int unsigned PNT_ERR_X   = 24;
  localparam int unsigned PNT_ERR_Y   = 25;
  localparam int unsigned STATUS      = 26;
  localparam int unsigned TIMESTAMP   = 27;
  localparam int unsigned COUNTER     = 28;

endpackage

// File: rtl/telemetry_frame_sequencer_decim.sv
// Sample-strobe decimator: asserts trigger on the strobe that completes
// each group of max(decim_i,1) enabled strobes.
module decim_counter #(
  parameter int unsigned DECIM_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [DECIM_W-1:0] decim_i,
  input  logic               strobe_i,
  output logic               trigger_o
);

  logic [DECIM_W-1:0] dcnt;
  logic [DECIM_W-1:0] term;

  always_comb begin
    term      = (decim_i == '0) ? '0 : decim_i - 1'b1;
    trigger_o = enable_i && strobe_i && (dcnt == term);
  end

  // A count already past a newly lowered ratio wraps to 0 without triggering.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
    end else if (!enable_i) begin
      dcnt <= '0;
    end else if (strobe_i) begin
      dcnt <= (dcnt >= term) ? '0 : dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/telemetry_frame_sequencer.sv
// Captures decimated datapath snapshots and streams each one as a header
// word followed by N_WORDS payload words; counts snapshots dropped while busy.
module telemetry_frame_sequencer #(
  parameter int unsigned N_WORDS   = telemetry_pkg::N_WORDS,
  parameter logic [15:0] SYNC_WORD = telemetry_pkg::SYNC_WORD,
  parameter int unsigned DECIM_W   = telemetry_pkg::DECIM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [DECIM_W-1:0]    decim_i,
  input  logic                  sample_valid_i,
  input  logic [32*N_WORDS-1:0] data_i,
  output logic [31:0]           m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic                  busy_o,
  output logic [15:0]           frame_seq_o,
  output logic [15:0]           overrun_cnt_o
);

  import telemetry_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_t                state, state_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [32*N_WORDS-1:0] snap;
  logic [15:0]           seq;
  logic [15:0]           ovr;
  logic                  trigger;
  logic                  hs;

  decim_counter #(
    .DECIM_W (DECIM_W)
  ) u_decim (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (enable_i),
    .decim_i   (decim_i),
    .strobe_i  (sample_valid_i),
    .trigger_o (trigger)
  );

  assign hs = m_tvalid_o & m_tready_i;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nx = HDR;
          idx_nx   = '0;
        end
      end
      HDR: begin
        if (hs) state_nx = PAY;
      end
      PAY: begin
        if (hs) begin
          if (idx == LAST_IDX) begin
            state_nx = IDLE;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode registered state only, so tready never reaches an output.
  always_comb begin
    m_tvalid_o = (state != IDLE);
    busy_o     = (state != IDLE);
    m_tlast_o  = (state == PAY) && (idx == LAST_IDX);
    m_tdata_o  = '0;
    case (state)
      HDR:     m_tdata_o = {SYNC_WORD, seq};
      PAY:     m_tdata_o = snap[32*idx +: 32];
      default: m_tdata_o = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      snap  <= '0;
      seq   <= '0;
      ovr   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (trigger && state == IDLE) begin
        snap <= data_i;
        seq  <= seq + 1'b1;
      end
      if (trigger && state != IDLE && ovr != '1) begin
        ovr <= ovr + 1'b1;
      end
    end
  end

  assign frame_seq_o   = seq;
  assign overrun_cnt_o = ovr;

endmodule
